// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the MEM-stage CPU port, the DMA/debug-loader port and the single-port dmem.
// The slave modport is the arbiter side; master is the requester/memory environment side.
interface dmem_port_arbiter_if;
  logic        cpu_ce;
  logic [29:0] cpu_addr;
  logic [3:0]  cpu_wstb;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dma_req;
  logic [29:0] dma_addr;
  logic [3:0]  dma_wstb;
  logic [31:0] dma_wdata;
  logic        dma_ack;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic        mem_ce;
  logic [29:0] mem_addr;
  logic [3:0]  mem_wstb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_ce, cpu_addr, cpu_wstb, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req, dma_addr, dma_wstb, dma_wdata,
    output dma_ack, dma_rvalid, dma_rdata, dma_err,
    output mem_ce, mem_addr, mem_wstb, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_ce, cpu_addr, cpu_wstb, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req, dma_addr, dma_wstb, dma_wdata,
    input  dma_ack, dma_rvalid, dma_rdata, dma_err,
    input  mem_ce, mem_addr, mem_wstb, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares single-port dmem between the CPU MEM stage (priority) and a DMA port, with a
// starvation counter that forces short DMA bursts while the pipeline is stalled.
module dmem_port_arbiter #(
  parameter logic [31:0] DMEM_BASE    = 32'h0010_0000,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned BURST_MAX    = 4
) (
  input logic               clk,
  input logic               rst_n,
  dmem_port_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BeatW   = $clog2(BURST_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);
  localparam logic [BeatW-1:0]   BeatMax   = BeatW'(BURST_MAX);
  localparam logic [BeatW-1:0]   BeatOne   = BeatW'(1);

  typedef enum logic {StCpu, StDma} state_e;
  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  state_e             state_q, state_d;
  logic [StarveW-1:0] starve_q, starve_d;
  logic [BeatW-1:0]   beat_q, beat_d;
  owner_e             owner_q, owner_d;
  logic               rvalid_q, rvalid_d;
  logic               err_q, err_d;

  logic cpu_gnt, dma_gnt, force_burst;
  logic cpu_win, dma_win;

  assign cpu_win = (bus.cpu_addr[29:18] == DMEM_BASE[31:20]);
  assign dma_win = (bus.dma_addr[29:18] == DMEM_BASE[31:20]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StCpu;
      starve_q <= '0;
      beat_q   <= '0;
      owner_q  <= OwnNone;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      beat_q   <= beat_d;
      owner_q  <= owner_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    beat_d   = beat_q;
    unique case (state_q)
      StCpu: begin
        if (dma_gnt) begin
          starve_d = '0;
        end else if (bus.dma_req && starve_q != StarveMax) begin
          starve_d = starve_q + 1'b1;
        end
        // The forcing cycle is itself the first beat of the burst.
        if (force_burst && BURST_MAX > 1) begin
          beat_d  = BeatOne;
          state_d = StDma;
        end
      end
      StDma: begin
        starve_d = '0;
        if (dma_gnt && beat_q != BeatMax) begin
          beat_d = beat_q + 1'b1;
        end
        if (!bus.dma_req || beat_d == BeatMax) begin
          state_d = StCpu;
          beat_d  = '0;
        end
      end
    endcase
  end

  // Output process: grants and the memory mux, gated by reset so outputs drop immediately.
  always_comb begin
    force_burst   = 1'b0;
    cpu_gnt       = 1'b0;
    dma_gnt       = 1'b0;
    bus.mem_ce    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wstb  = '0;
    bus.mem_wdata = '0;
    if (rst_n) begin
      unique case (state_q)
        StCpu: begin
          force_burst = (starve_q == StarveMax) && bus.dma_req && bus.cpu_ce;
          dma_gnt     = bus.dma_req && (!bus.cpu_ce || force_burst);
        end
        StDma: dma_gnt = bus.dma_req;
      endcase
      cpu_gnt = bus.cpu_ce && !dma_gnt;
    end
    if (dma_gnt) begin
      bus.mem_ce    = dma_win;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wstb  = bus.dma_wstb;
      bus.mem_wdata = bus.dma_wdata;
    end else if (cpu_gnt) begin
      bus.mem_ce    = cpu_win;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wstb  = bus.cpu_wstb;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

  always_comb begin
    owner_d = OwnNone;
    if (cpu_gnt && bus.cpu_wstb == 4'b0000 && cpu_win) begin
      owner_d = OwnCpu;
    end else if (dma_gnt && bus.dma_wstb == 4'b0000 && dma_win) begin
      owner_d = OwnDma;
    end
    rvalid_d = dma_gnt && (bus.dma_wstb == 4'b0000);
    err_d    = dma_gnt && !dma_win;
  end

  assign bus.cpu_stall  = bus.cpu_ce && dma_gnt;
  assign bus.dma_ack    = dma_gnt;
  assign bus.cpu_rdata  = (owner_q == OwnCpu) ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = (owner_q == OwnDma) ? bus.mem_rdata : '0;
  assign bus.dma_rvalid = rvalid_q;
  assign bus.dma_err    = err_q;

endmodule
